// File: rtl/fpu_divsqrt_iter_pkg.sv
// Shared FPU constants and the state type for the iterative divide/square-root unit.
package fpu_divsqrt_iter_pkg;

  localparam logic [4:0] OP_FDIV    = 5'b00011;
  localparam logic [4:0] OP_FSQRT   = 5'b01011;
  localparam int         MANT_W_DEF = 24;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_RUN  = 2'd1,
    DS_DONE = 2'd2
  } ds_state_e;

endpackage

// File: rtl/fpu_divsqrt_step.sv
// One restoring radix-2 iteration, shared by divide (remainder vs divisor)
// and square root (remainder with two radicand bits appended vs {root,01}).
module fpu_divsqrt_step
  import fpu_divsqrt_iter_pkg::*;
#(
  parameter int RW = 29,
  parameter int QW = 26
) (
  input  logic [RW-1:0] i_rem,
  input  logic [QW-1:0] i_den,
  input  logic [1:0]    i_rad,
  input  logic          i_sqrt,
  output logic [RW-1:0] o_rem,
  output logic          o_bit,
  output logic          o_spill
);

  logic [RW-1:0] w_cur;
  logic [RW-1:0] w_sub;
  logic [RW-1:0] w_keep;

  always_comb begin
    w_cur   = i_sqrt ? {i_rem[RW-3:0], i_rad} : i_rem;
    w_sub   = i_sqrt ? RW'({i_den, 2'b01}) : RW'(i_den);
    o_bit   = (w_cur >= w_sub);
    w_keep  = o_bit ? (w_cur - w_sub) : w_cur;
    o_rem   = i_sqrt ? w_keep : {w_keep[RW-2:0], 1'b0};
    // A divide by zero keeps doubling the remainder; flag any bit pushed out the top.
    o_spill = i_sqrt ? (|i_rem[RW-1:RW-2]) : w_keep[RW-1];
  end

endmodule

// File: rtl/fpu_divsqrt_iter.sv
// Iterative radix-2 mantissa divider / square-root unit with a one-cycle done pulse.
// Optional FPU_DIVSQRT_EARLY_EXIT_EN: finish as soon as the partial remainder is exactly zero.
module fpu_divsqrt_iter
  import fpu_divsqrt_iter_pkg::*;
#(
  parameter int MANT_W = MANT_W_DEF,
  parameter int ITER   = MANT_W + 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_in_sel,
  input  logic [4:0]        i_op,
  input  logic [MANT_W-1:0] i_mant_a,
  input  logic [MANT_W-1:0] i_mant_b,
  input  logic              i_exp_odd,
  output logic              o_busy,
  output logic              o_done,
  output logic [ITER-1:0]   o_result,
  output logic              o_sticky,
  output logic              o_div_zero
);

  localparam int RW   = ITER + 3;
  localparam int RADW = 2 * ITER;
  localparam int CW   = $clog2(ITER + 1);

  ds_state_e         r_state;
  ds_state_e         w_next;
  logic [CW-1:0]     r_cnt;
  logic [RW-1:0]     r_rem;
  logic [RW-1:0]     w_rem;
  logic [ITER-1:0]   r_q;
  logic [ITER-1:0]   w_den;
  logic [ITER-1:0]   w_res;
  logic [MANT_W-1:0] r_b;
  logic [RADW-1:0]   r_rad;
  logic [MANT_W:0]   w_rad_x;
  logic              r_sqrt;
  logic              r_spill;
  logic              r_dz;
  logic              w_bit;
  logic              w_spill;
  logic              w_launch;
  logic              w_finish;
  logic              w_step;
  logic              w_load;

  assign w_launch = i_start && i_in_sel && (i_op == OP_FDIV || i_op == OP_FSQRT);
  assign w_load   = (r_state == DS_IDLE) && w_launch;
  assign w_step   = (r_state == DS_RUN) && !w_finish;
  assign w_den    = r_sqrt ? r_q : ITER'(r_b);
  // Radicand in [1,4): two integer bits, zero-padded so every iteration consumes a pair.
  assign w_rad_x  = i_exp_odd ? {i_mant_a, 1'b0} : {1'b0, i_mant_a};

`ifdef FPU_DIVSQRT_EARLY_EXIT_EN
  logic w_zero;
  assign w_zero   = (r_cnt != '0) && (r_rem == '0) && (r_rad == '0) && !r_spill;
  assign w_finish = (r_cnt == CW'(ITER)) || w_zero;
  assign w_res    = r_q << (CW'(ITER) - r_cnt);
`else
  assign w_finish = (r_cnt == CW'(ITER));
  assign w_res    = r_q;
`endif

  fpu_divsqrt_step #(
    .RW (RW),
    .QW (ITER)
  ) u_step (
    .i_rem   (r_rem),
    .i_den   (w_den),
    .i_rad   (r_rad[RADW-1 -: 2]),
    .i_sqrt  (r_sqrt),
    .o_rem   (w_rem),
    .o_bit   (w_bit),
    .o_spill (w_spill)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) r_state <= DS_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      DS_IDLE: if (w_launch) w_next = DS_RUN;
      DS_RUN: begin
        if (!i_start)      w_next = DS_IDLE;
        else if (w_finish) w_next = DS_DONE;
      end
      DS_DONE: w_next = DS_IDLE;
      default: w_next = DS_IDLE;
    endcase
  end

  always_comb begin
    o_busy = (r_state == DS_RUN);
    o_done = (r_state == DS_DONE);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt      <= '0;
      o_result   <= '0;
      o_sticky   <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      if (w_load)      r_cnt <= '0;
      else if (w_step) r_cnt <= r_cnt + 1'b1;
      // An abort in the final cycle wins: outputs keep the previous completion.
      if ((r_state == DS_RUN) && i_start && w_finish) begin
        o_result   <= w_res;
        o_sticky   <= (|r_rem) | r_spill;
        o_div_zero <= r_dz;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_load) begin
      r_sqrt  <= (i_op == OP_FSQRT);
      r_rem   <= (i_op == OP_FSQRT) ? '0 : RW'(i_mant_a);
      r_q     <= '0;
      r_b     <= i_mant_b;
      r_rad   <= (i_op == OP_FSQRT) ? {w_rad_x, {(RADW-MANT_W-1){1'b0}}} : '0;
      r_spill <= 1'b0;
      r_dz    <= (i_op == OP_FDIV) && (i_mant_b == '0);
    end else if (w_step) begin
      r_rem   <= w_rem;
      r_q     <= {r_q[ITER-2:0], w_bit};
      r_rad   <= {r_rad[RADW-3:0], 2'b00};
      r_spill <= r_spill | w_spill;
    end
  end

endmodule

// File: doc/fpu_divsqrt_iter.md
# fpu_divsqrt_iter

Iterative radix-2 mantissa divider / square-root unit for the FPU arithmetic path. Consumes the `start`/`op` command and the normalized mantissas latched in the A/B operand registers. Runs a restoring digit recurrence and returns a one-cycle `done` pulse to the FPU top controller, which holds its multi-cycle state until `done`. Rounding, exponent handling and special-value detection stay outside this block.

## Interface
- `MANT_W`, 24, mantissa width including hidden bit
- `ITER`, `MANT_W+2`, quotient/root bits produced (result plus guard and round)

- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-low
- `start`  in  1  FPU command valid, level; held by core for whole operation
- `in_sel`  in  1  controller operand-load phase; launch allowed only when 1
- `op`  in  5  FPU opcode; `5'b00011` = FDIV, `5'b01011` = FSQRT, others ignored
- `mant_a`  in  `MANT_W`  dividend / radicand mantissa, bit `MANT_W-1` = 1
- `mant_b`  in  `MANT_W`  divisor mantissa
- `exp_odd`  in  1  FSQRT only: radicand = `mant_a`×2 when 1, else `mant_a`
- `busy`  out  1  iteration in progress
- `done`  out  1  single-cycle completion pulse
- `result`  out  `ITER`  quotient/root; bit `ITER-1` weight 2^0
- `sticky`  out  1  final partial remainder non-zero
- `div_zero`  out  1  FDIV launched with `mant_b == 0`

## Operation
- States: IDLE, RUN, DONE.
- IDLE→RUN on launch = `start && in_sel && (op==FDIV || op==FSQRT)`.
  - Launch captures operands, op class and `exp_odd`.
  - Launch clears iteration counter and partial remainder/root.
  - Launch sets `div_zero = (op==FDIV && mant_b==0)`.
- RUN: one result bit per cycle, MSB first.
- FDIV is restoring:
  - If `R ≥ B`, take bit 1 and `R -= B`; otherwise bit 0.
  - Then `R <<= 1`.
  - Initial `R = mant_a`. Remainder register is at least `MANT_W+2` bits.
- FSQRT is restoring digit-by-digit on a radicand in [1,4).
  - Two radicand bits enter per cycle.
  - Trial subtrahend is `{root,01}`.
- RUN→DONE after `ITER` iterations; `done` = 1 in DONE only.
- DONE→IDLE unconditionally next cycle.
  - A launch may occur in that IDLE cycle (back-to-back).
- Abort: `start == 0` while in RUN → IDLE next edge, no `done`, `result` not updated.
- `result`, `sticky`, `div_zero` are registered.
  - They update at the RUN→DONE edge and hold until the next completion.
- Divide by zero is not special-cased in the datapath.
  - Natural recurrence gives `result` all ones and `sticky` = 1.
  - `div_zero` flags it.
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `sticky` 0, `div_zero` 0, counter 0.

## Timing
- Launch sampled at edge E0; `busy` = 1 from E0 through the final RUN cycle.
- `done` high for exactly one cycle, starting at edge E0+`ITER`+1 (27 cycles for `MANT_W` = 24).
- `result`/`sticky` valid in the `done` cycle and stable afterwards.
- Launch inputs are ignored while `busy` or in DONE.
- Async `reset` mid-operation clears everything immediately; no `done` follows.

## Configuration
- `FPU_DIVSQRT_EARLY_EXIT_EN` defined:
  - If partial remainder becomes 0 after iteration k < `ITER`, RUN→DONE at that edge.
  - Remaining low result bits forced 0, `sticky` = 0.
  - `done` occurs at E0+k+1.
- Undefined: fixed `ITER`+1 latency for every operation, no remainder-zero detect logic.

## Structure
- Shared FPU package holds:
  - `OP_FDIV` and `OP_FSQRT` opcode constants.
  - `MANT_W` default.
  - Divsqrt state enum (IDLE/RUN/DONE).
- Sub-module `fpu_divsqrt_step`: purely combinational single iteration.
  - Inputs: partial remainder, divisor or partial root, next radicand bits, op class.
  - Outputs: next remainder and result bit.
- Top holds FSM, counter, registers.

## Test plan
- FDIV `mant_a=24'hC00000`, `mant_b=24'h800000` → `done` at E0+27, `result=26'h3000000`, `sticky=0`, `div_zero=0`.
- FDIV `mant_a=24'h800000`, `mant_b=24'hC00000` → `result=26'h1555555`, `sticky=1`.
- FSQRT `exp_odd=1`, `mant_a=24'h800000` → `result=26'h2D413CC`, `sticky=1`.
- FSQRT `exp_odd=1`, `mant_a=24'h900000` → `result=26'h3000000`, `sticky=0`.
  - With the early-exit macro, `done` arrives before E0+27.
- FDIV `mant_b=0` → `div_zero=1`, `result=26'h3FFFFFF`, `sticky=1`, normal latency.
- Abort and reset cases:
  - Drop `start` at E0+10 → `busy` 0 next cycle, no `done`.
  - A fresh launch then completes correctly.
  - Async `reset` asserted at E0+5 → all outputs 0, no `done`.
